i2s_sample_fifo: RTL and testbench

//  Downstream of the I2S receiver. Captures each decoded stereo pair {left,right} on the

---
 rtl/i2s_sample_fifo.sv | 113 +++++++++++
 tb/tb_i2s_sample_fifo.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_sample_fifo.sv
// Stereo sample FIFO behind the I2S receiver: captures {left,right} on the strobe's
// trailing edge, buffers DEPTH pairs, and presents them first-word-fall-through.

module i2s_fifo_lane #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

module i2s_sample_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] left_in,
  input  logic [WIDTH-1:0] right_in,
  input  logic             sample_stb,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_left,
  output logic [WIDTH-1:0] m_right,
  output logic [AW:0]      level,
  output logic             overflow,
  output logic [15:0]      drop_count,
  input  logic             clear_ovf
);
  localparam int NUM_LANES = 2;
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic                            stb_d;
  logic                            cap, push, pop, full, empty, drop;
  logic [AW-1:0]                   wr_ptr, rd_ptr;
  logic [NUM_LANES-1:0][WIDTH-1:0] wr_data, rd_data;

  // Right word only settles at the trailing edge, so capture on the fall.
  assign cap   = stb_d & ~sample_stb;
  assign full  = (level == FULL_LVL);
  assign empty = (level == '0);
  assign pop   = m_valid & m_ready;
  assign push  = cap & (~full | pop);
  assign drop  = cap & full & ~pop;

  assign wr_data[0] = left_in;
  assign wr_data[1] = right_in;

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      i2s_fifo_lane #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_lane (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wr_data[g]),
        .raddr (rd_ptr),
        .rdata (rd_data[g])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      stb_d  <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      stb_d <= sample_stb;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // A drop in the same cycle as clear_ovf must remain visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow   <= 1'b1;
      if (clear_ovf)                  drop_count <= 16'd1;
      else if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end else if (clear_ovf) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end
  end

  // Outputs depend only on registered state; m_ready never reaches them.
  assign m_valid = ~empty;
  assign m_left  = m_valid ? rd_data[0] : '0;
  assign m_right = m_valid ? rd_data[1] : '0;
endmodule

// File: tb/tb_i2s_sample_fifo.sv
// Scoreboard bench for i2s_sample_fifo: a reference queue mirrors the FIFO and every
// popped pair, level and overflow state is compared against it.

module tb_i2s_sample_fifo;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] left_in = '0, right_in = '0;
  logic        sample_stb = 1'b0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [15:0] m_left, m_right;
  logic [4:0]  level;
  logic        overflow;
  logic [15:0] drop_count;
  logic        clear_ovf = 1'b0;

  i2s_sample_fifo #(.WIDTH(16), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .left_in(left_in), .right_in(right_in),
    .sample_stb(sample_stb), .m_valid(m_valid), .m_ready(m_ready),
    .m_left(m_left), .m_right(m_right), .level(level), .overflow(overflow),
    .drop_count(drop_count), .clear_ovf(clear_ovf)
  );

  always #5 clk = ~clk;

  logic [31:0] sb[$];
  bit          stb_prev = 1'b0;
  bit          exp_ovf = 1'b0;
  int          exp_drops = 0;
  int          n_checks = 0, n_fail = 0;

  // One clock of the reference model; DUT outputs are sampled on the falling edge.
  task automatic step(output bit popd, output logic [31:0] exp_h, output logic [31:0] obs_h);
    bit full, cap;
    @(negedge clk);
    obs_h = {m_left, m_right};
    popd  = 1'b0;
    exp_h = 'x;
    if (rst) begin
      sb.delete();
      exp_ovf   = 1'b0;
      exp_drops = 0;
    end else begin
      full = (sb.size() == 16);
      cap  = stb_prev && !sample_stb;
      if (sb.size() > 0 && m_ready) begin
        popd  = 1'b1;
        exp_h = sb.pop_front();
      end
      if (cap && (!full || popd)) sb.push_back({left_in, right_in});
      if (cap && full && !popd) begin
        exp_ovf   = 1'b1;
        exp_drops = clear_ovf ? 1 : (exp_drops == 65535 ? 65535 : exp_drops + 1);
      end else if (clear_ovf) begin
        exp_ovf   = 1'b0;
        exp_drops = 0;
      end
    end
    @(posedge clk); #1;
    stb_prev = rst ? 1'b0 : sample_stb;
  endtask

  task automatic send(input logic [15:0] l, input logic [15:0] r, input int hi);
    bit p; logic [31:0] e, o;
    m_ready = 1'b0;
    left_in = l; right_in = r; sample_stb = 1'b1;
    repeat (hi) step(p, e, o);
    sample_stb = 1'b0;
    step(p, e, o);
  endtask

  task automatic test_reset();
    bit p; logic [31:0] e, o;
    rst = 1'b1;
    repeat (2) step(p, e, o);
    rst = 1'b0;
    n_checks++;
    if (level !== 5'd0 || m_valid !== 1'b0 || m_left !== 16'h0 || m_right !== 16'h0 ||
        overflow !== 1'b0 || drop_count !== 16'h0) begin
      n_fail++;
      $display("FAIL reset: level=%0d valid=%b l=%h r=%h ovf=%b drops=%0d, want all zero",
               level, m_valid, m_left, m_right, overflow, drop_count);
    end
  endtask

  task automatic test_single();
    bit p; logic [31:0] e, o;
    left_in = 16'h1234; right_in = 16'hABCD; sample_stb = 1'b1;
    repeat (3) step(p, e, o);
    n_checks++;
    if (level !== 5'd0 || m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_lead: level=%0d valid=%b during strobe, want 0/0", level, m_valid);
    end
    sample_stb = 1'b0;
    step(p, e, o);
    n_checks++;
    if (m_valid !== 1'b1 || m_left !== 16'h1234 || m_right !== 16'hABCD || level !== 5'd1) begin
      n_fail++;
      $display("FAIL single_pair: valid=%b l=%h r=%h level=%0d, want 1 1234 abcd 1",
               m_valid, m_left, m_right, level);
    end
    m_ready = 1'b1;
    step(p, e, o);
    m_ready = 1'b0;
    n_checks++;
    if (!p || o !== e || level !== 5'd0) begin
      n_fail++;
      $display("FAIL single_pop: popped=%b got=%h want=%h level=%0d", p, o, e, level);
    end
  endtask

  task automatic test_long_strobe();
    bit p; logic [31:0] e, o;
    send(16'h0BEE, 16'hF00D, 20);
    step(p, e, o);
    n_checks++;
    if (level !== 5'd1 || level !== 5'(sb.size()) || {m_left, m_right} !== 32'h0BEEF00D) begin
      n_fail++;
      $display("FAIL long_strobe: level=%0d head=%h%h, want 1 0beef00d", level, m_left, m_right);
    end
    m_ready = 1'b1;
    step(p, e, o);
    m_ready = 1'b0;
    n_checks++;
    if (!p || o !== e || level !== 5'd0) begin
      n_fail++;
      $display("FAIL long_pop: popped=%b got=%h want=%h level=%0d", p, o, e, level);
    end
  endtask

  task automatic test_order_wrap();
    bit p; logic [31:0] e, o;
    int sent = 0, got = 0;
    m_ready = 1'b1;
    for (int c = 0; c < 400 && got < 40; c++) begin
      if (sent < 40) begin
        if (!sample_stb) begin
          left_in = 16'(sent); right_in = 16'(sent) + 16'h0100; sample_stb = 1'b1;
        end else begin
          sample_stb = 1'b0; sent++;
        end
      end
      step(p, e, o);
      if (p) begin
        n_checks++;
        if (o !== e || o !== {16'(got), 16'(got) + 16'h0100}) begin
          n_fail++;
          $display("FAIL order_%0d: got=%h want=%h", got, o, e);
        end
        got++;
      end
      m_ready = ~m_ready;
    end
    m_ready = 1'b0;
    n_checks++;
    if (got != 40 || level !== 5'd0 || m_valid !== 1'b0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL order_end: popped=%0d level=%0d valid=%b ovf=%b, want 40 0 0 0",
               got, level, m_valid, overflow);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 18; i++) send(16'h0200 + 16'(i), 16'h0300 + 16'(i), 1);
    n_checks++;
    if (level !== 5'd16 || overflow !== 1'b1 || drop_count !== 16'd2 ||
        {m_left, m_right} !== 32'h02000300 || drop_count !== 16'(exp_drops)) begin
      n_fail++;
      $display("FAIL overflow: level=%0d ovf=%b drops=%0d head=%h%h, want 16 1 2 02000300",
               level, overflow, drop_count, m_left, m_right);
    end
  endtask

  task automatic test_full_pop();
    bit p; logic [31:0] e, o;
    int n = 0;
    left_in = 16'h5A5A; right_in = 16'hA5A5; sample_stb = 1'b1;
    step(p, e, o);
    sample_stb = 1'b0; m_ready = 1'b1;
    step(p, e, o);
    m_ready = 1'b0;
    n_checks++;
    if (!p || o !== 32'h02000300 || level !== 5'd16 || drop_count !== 16'd2) begin
      n_fail++;
      $display("FAIL full_pop: popped=%b got=%h level=%0d drops=%0d, want 02000300 16 2",
               p, o, level, drop_count);
    end
    m_ready = 1'b1;
    for (int c = 0; c < 40 && n < 16; c++) begin
      step(p, e, o);
      if (p) begin
        n++;
        n_checks++;
        if (o !== e || (n == 16 && o !== 32'h5A5AA5A5)) begin
          n_fail++;
          $display("FAIL drain_%0d: got=%h want=%h", n, o, e);
        end
      end
    end
    m_ready = 1'b0;
    n_checks++;
    if (n != 16 || level !== 5'd0) begin
      n_fail++;
      $display("FAIL drain_end: popped=%0d level=%0d, want 16 0", n, level);
    end
  endtask

  task automatic test_clear_drop();
    bit p; logic [31:0] e, o;
    for (int i = 0; i < 16; i++) send(16'h0400 + 16'(i), 16'h0500 + 16'(i), 1);
    left_in = 16'hDEAD; right_in = 16'hBEEF; sample_stb = 1'b1;
    step(p, e, o);
    sample_stb = 1'b0; clear_ovf = 1'b1;
    step(p, e, o);
    clear_ovf = 1'b0;
    n_checks++;
    if (overflow !== 1'b1 || drop_count !== 16'd1 || level !== 5'd16) begin
      n_fail++;
      $display("FAIL clear_drop: ovf=%b drops=%0d level=%0d, want 1 1 16",
               overflow, drop_count, level);
    end
    clear_ovf = 1'b1;
    step(p, e, o);
    clear_ovf = 1'b0;
    n_checks++;
    if (overflow !== 1'b0 || drop_count !== 16'd0 || overflow !== exp_ovf) begin
      n_fail++;
      $display("FAIL clear_only: ovf=%b drops=%0d, want 0 0", overflow, drop_count);
    end
  endtask

  task automatic test_rst_mid();
    bit p; logic [31:0] e, o;
    rst = 1'b1; step(p, e, o); rst = 1'b0;
    for (int i = 0; i < 5; i++) send(16'h0600 + 16'(i), 16'h0700 + 16'(i), 2);
    n_checks++;
    if (level !== 5'd5 || {m_left, m_right} !== 32'h06000700) begin
      n_fail++;
      $display("FAIL pre_rst: level=%0d head=%h%h, want 5 06000700", level, m_left, m_right);
    end
    rst = 1'b1; step(p, e, o); rst = 1'b0;
    n_checks++;
    if (level !== 5'd0 || m_valid !== 1'b0 || m_left !== 16'h0 || m_right !== 16'h0) begin
      n_fail++;
      $display("FAIL rst_mid: level=%0d valid=%b l=%h r=%h, want 0 0 0 0",
               level, m_valid, m_left, m_right);
    end
    // strobe held high across reset release
    left_in = 16'h7777; right_in = 16'h8888; sample_stb = 1'b1; rst = 1'b1;
    step(p, e, o);
    rst = 1'b0;
    step(p, e, o);
    sample_stb = 1'b0;
    step(p, e, o);
    step(p, e, o);
    n_checks++;
    if (level !== 5'd1 || level !== 5'(sb.size()) || {m_left, m_right} !== 32'h77778888) begin
      n_fail++;
      $display("FAIL stb_across_rst: level=%0d head=%h%h, want 1 77778888",
               level, m_left, m_right);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_long_strobe();
    test_order_wrap();
    test_overflow();
    test_full_pop();
    test_clear_drop();
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "timeout");
  end
endmodule
